// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: opcode/flag inputs, control-store write port and sequencer outputs
interface micro_sequencer_if #(
   parameter int CW_WIDTH   = 32,
   parameter int CAR_WIDTH  = 8,
   parameter int OP_WIDTH   = 8,
   parameter int FLAG_WIDTH = 8
);
   localparam int CSEL = $clog2(FLAG_WIDTH);
   localparam int UW   = 3 + CSEL + CAR_WIDTH + CW_WIDTH;
   logic [OP_WIDTH-1:0]   data_from_ir;
   logic [FLAG_WIDTH-1:0] flags;
   logic                  resume;
   logic                  ucode_we;
   logic [CAR_WIDTH-1:0]  ucode_addr;
   logic [UW-1:0]         ucode_wdata;
   logic [CW_WIDTH-1:0]   control_signal;
   logic [CAR_WIDTH-1:0]  car;
   logic                  halted;
   logic                  illegal_op;
   modport master (
      output data_from_ir, flags, resume, ucode_we, ucode_addr, ucode_wdata,
      input  control_signal, car, halted, illegal_op
   );
   modport slave (
      input  data_from_ir, flags, resume, ucode_we, ucode_addr, ucode_wdata,
      output control_signal, car, halted, illegal_op
   );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: writable control store with next/fetch/map/goto/branch/halt sequencing
module micro_sequencer #(
   parameter int CW_WIDTH   = 32,
   parameter int CAR_WIDTH  = 8,
   parameter int OP_WIDTH   = 8,
   parameter int FLAG_WIDTH = 8,
   parameter int MAP_SHIFT  = 3
) (
   input logic clk,
   input logic rst,
   micro_sequencer_if.slave bus
);
   localparam int CSEL = $clog2(FLAG_WIDTH);
   localparam int UW   = 3 + CSEL + CAR_WIDTH + CW_WIDTH;
   typedef enum logic [2:0] {NEXT, FETCH, MAP, GOTO, BRSET, BRCLR, HALT, RSVD} seq_t;
   typedef enum logic {S_RUN, S_HALT} state_t;
   logic [UW-1:0]        store [2**CAR_WIDTH];
   logic [2:0]           seq;
   logic [CSEL-1:0]      csel;
   logic [CAR_WIDTH-1:0] car, na, inc, map_addr, nxt;
   logic [CW_WIDTH-1:0]  ctrl, cs;
   logic                 cond, legal, illegal;
   state_t               state;
   assign {seq, csel, na, ctrl} = store[car];
   assign inc      = car + 1'b1;
   assign map_addr = CAR_WIDTH'({{CAR_WIDTH{1'b0}}, bus.data_from_ir} << MAP_SHIFT);
   assign legal    = (bus.data_from_ir >> (CAR_WIDTH - MAP_SHIFT)) == '0;
   // selectors beyond the flag vector read as a false condition
   assign cond     = int'(csel) < FLAG_WIDTH && bus.flags[csel];
   always_comb
      nxt = seq == FETCH ? '0 :
            seq == MAP   ? (legal ? map_addr : '0) :
            seq == GOTO  ? na :
            seq == BRSET ? (cond ? na : inc) :
            seq == BRCLR ? (!cond ? na : inc) :
            seq == HALT  ? car : inc;
   // store writes are independent of reset and sequencer state
   always_ff @(posedge clk)
      if (bus.ucode_we) store[bus.ucode_addr] <= bus.ucode_wdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_RUN;
         car     <= '0;
         cs      <= '0;
         illegal <= 1'b0;
      end else if (state == S_HALT) begin
         cs      <= '0;
         illegal <= 1'b0;
         if (bus.resume) begin
            state <= S_RUN;
            car   <= '0;
         end
      end else begin
         cs      <= ctrl;
         car     <= nxt;
         illegal <= seq == MAP && !legal;
         state   <= seq == HALT ? S_HALT : S_RUN;
      end
   end
   assign bus.control_signal = cs;
   assign bus.car            = car;
   assign bus.halted         = state == S_HALT;
   assign bus.illegal_op     = illegal;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vectors through reset load, map, branches, halt/resume, wrap and live writes
module tb_micro_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_errors = 0;
   micro_sequencer_if sif ();
   micro_sequencer dut (.clk(clk), .rst(rst), .bus(sif));
   always #5 clk = ~clk;

   localparam logic [2:0] NEXT = 3'd0, MAP = 3'd2, GOTO = 3'd3, BRSET = 3'd4, BRCLR = 3'd5, HALT = 3'd6;

   function automatic logic [45:0] uw(input logic [2:0] s, input logic [2:0] c,
                                      input logic [7:0] na, input logic [31:0] ctrl);
      return {s, c, na, ctrl};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [7:0] c, input logic [31:0] cs,
                               input logic h, input logic il);
      check({tag, ".car"}, 64'(sif.car), 64'(c));
      check({tag, ".cs"}, 64'(sif.control_signal), 64'(cs));
      check({tag, ".halted"}, 64'(sif.halted), 64'(h));
      check({tag, ".illegal"}, 64'(sif.illegal_op), 64'(il));
   endtask

   task automatic wr(input logic [7:0] a, input logic [45:0] w);
      sif.ucode_we    = 1'b1;
      sif.ucode_addr  = a;
      sif.ucode_wdata = w;
      tick();
      sif.ucode_we    = 1'b0;
   endtask

   initial begin
      sif.data_from_ir = 8'h00;
      sif.flags        = 8'h00;
      sif.resume       = 1'b0;
      sif.ucode_we     = 1'b0;
      sif.ucode_addr   = 8'h00;
      sif.ucode_wdata  = '0;
      tick();
      wr(8'h00, uw(NEXT, 3'd0, 8'h00, 32'h20));
      wr(8'h01, uw(NEXT, 3'd0, 8'h00, 32'h10));
      wr(8'h02, uw(MAP, 3'd0, 8'h00, 32'h2000));
      wr(8'h10, uw(GOTO, 3'd0, 8'h28, 32'h11));
      wr(8'h28, uw(BRSET, 3'd7, 8'h30, 32'h1));
      wr(8'h29, uw(BRCLR, 3'd0, 8'hFF, 32'h29));
      wr(8'h30, uw(GOTO, 3'd0, 8'h38, 32'h30));
      wr(8'h38, uw(HALT, 3'd0, 8'h00, 32'h8));
      wr(8'hFF, uw(NEXT, 3'd0, 8'h00, 32'hFF));
      expect_state("reset", 8'h00, 32'h0, 1'b0, 1'b0);
      // run from address 0 through map, goto, taken BRSET and into HALT
      sif.data_from_ir = 8'h02;
      sif.flags        = 8'h80;
      rst = 1'b0;
      tick(); expect_state("w0", 8'h01, 32'h20, 1'b0, 1'b0);
      tick(); expect_state("w1", 8'h02, 32'h10, 1'b0, 1'b0);
      tick(); expect_state("map", 8'h10, 32'h2000, 1'b0, 1'b0);
      tick(); expect_state("goto", 8'h28, 32'h11, 1'b0, 1'b0);
      tick(); expect_state("brset_t", 8'h30, 32'h1, 1'b0, 1'b0);
      tick(); expect_state("goto38", 8'h38, 32'h30, 1'b0, 1'b0);
      tick(); expect_state("halt_ctrl", 8'h38, 32'h8, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         sif.flags        = 8'(i * 37);
         sif.data_from_ir = 8'(i * 13);
         tick(); expect_state("halted", 8'h38, 32'h0, 1'b1, 1'b0);
      end
      sif.resume = 1'b1;
      tick(); expect_state("resume", 8'h00, 32'h0, 1'b0, 1'b0);
      sif.resume = 1'b0;
      tick(); expect_state("after_resume", 8'h01, 32'h20, 1'b0, 1'b0);
      sif.resume = 1'b1;
      tick(); expect_state("resume_ignored", 8'h02, 32'h10, 1'b0, 1'b0);
      sif.resume = 1'b0;
      // unmapped opcode
      sif.data_from_ir = 8'h20;
      tick(); expect_state("illegal", 8'h00, 32'h2000, 1'b0, 1'b1);
      tick(); expect_state("illegal_end", 8'h01, 32'h20, 1'b0, 1'b0);
      // not-taken BRSET, taken BRCLR to 0xFF, then wrap
      sif.data_from_ir = 8'h05;
      sif.flags        = 8'h00;
      tick(); expect_state("w1b", 8'h02, 32'h10, 1'b0, 1'b0);
      tick(); expect_state("map05", 8'h28, 32'h2000, 1'b0, 1'b0);
      tick(); expect_state("brset_nt", 8'h29, 32'h1, 1'b0, 1'b0);
      tick(); expect_state("brclr_t", 8'hFF, 32'h29, 1'b0, 1'b0);
      tick(); expect_state("wrap", 8'h00, 32'hFF, 1'b0, 1'b0);
      // overwrite the word currently executing
      sif.data_from_ir = 8'h00;
      wr(8'h00, uw(NEXT, 3'd0, 8'h00, 32'h55));
      expect_state("old_word", 8'h01, 32'h20, 1'b0, 1'b0);
      tick(); expect_state("w1c", 8'h02, 32'h10, 1'b0, 1'b0);
      tick(); expect_state("map00", 8'h00, 32'h2000, 1'b0, 1'b0);
      tick(); expect_state("new_word", 8'h01, 32'h55, 1'b0, 1'b0);
      // reset while sitting on a branch
      sif.data_from_ir = 8'h05;
      sif.flags        = 8'h80;
      tick(); expect_state("w1d", 8'h02, 32'h10, 1'b0, 1'b0);
      tick(); expect_state("map05b", 8'h28, 32'h2000, 1'b0, 1'b0);
      rst = 1'b1;
      tick(); expect_state("mid_rst", 8'h00, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      tick(); expect_state("store_kept", 8'h01, 32'h55, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter CW_WIDTH, default 32, control word width.
REQ-002 Parameter CAR_WIDTH, default 8, control address register width; control store depth is 2^CAR_WIDTH.
REQ-003 Parameter OP_WIDTH, default 8, opcode width.
REQ-004 Parameter FLAG_WIDTH, default 8, flag vector width; CSEL = clog2(FLAG_WIDTH).
REQ-005 Parameter MAP_SHIFT, default 3, opcode-to-address shift (8 microwords per opcode).
REQ-006 Derived microword width UW = 3 + CSEL + CAR_WIDTH + CW_WIDTH; field order MSB->LSB: seq[2:0], csel, next_addr, ctrl.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 data_from_ir  input  OP_WIDTH  current instruction opcode.
REQ-010 flags  input  FLAG_WIDTH  ALU/status flags for conditional branches.
REQ-011 resume  input  1  one-cycle pulse leaving HALT.
REQ-012 ucode_we  input  1  control store write enable.
REQ-013 ucode_addr  input  CAR_WIDTH  control store write address.
REQ-014 ucode_wdata  input  UW  microword to write.
REQ-015 control_signal  output  CW_WIDTH  registered control word.
REQ-016 car  output  CAR_WIDTH  current control address.
REQ-017 halted  output  1  high while in HALT state.
REQ-018 illegal_op  output  1  one-cycle pulse on unmapped opcode.

Function
REQ-019 Control store SHALL be a 2^CAR_WIDTH x UW array with asynchronous read at car and synchronous write at ucode_addr when ucode_we=1.
REQ-020 Write to the address being executed in the same cycle SHALL not affect that cycle; new word executes on next visit.
REQ-021 When not halted, each cycle SHALL execute microword M = store[car]: control_signal <= M.ctrl, car <= next address per seq.
REQ-022 seq 000 NEXT: car <= car+1, wrapping from 2^CAR_WIDTH-1 to 0.
REQ-023 seq 001 FETCH: car <= 0.
REQ-024 seq 010 MAP: car <= data_from_ir << MAP_SHIFT (truncated to CAR_WIDTH), using opcode sampled this cycle.
REQ-025 MAP with data_from_ir >= 2^(CAR_WIDTH-MAP_SHIFT): car <= 0, illegal_op=1 for one cycle, control_signal <= M.ctrl.
REQ-026 seq 011 GOTO: car <= M.next_addr.
REQ-027 seq 100 BRSET: car <= M.next_addr if flags[M.csel]=1, else car+1.
REQ-028 seq 101 BRCLR: car <= M.next_addr if flags[M.csel]=0, else car+1.
REQ-029 csel >= FLAG_WIDTH SHALL be treated as condition false.
REQ-030 seq 110 HALT: control_signal <= M.ctrl, car held, halted <= 1 next cycle.
REQ-031 seq 111 reserved: behaves as NEXT.
REQ-032 While halted: control_signal = 0, car held, flags/opcode ignored; resume=1 -> car <= 0, halted <= 0, control_signal stays 0 that cycle; first word from address 0 is emitted next cycle.
REQ-033 resume while not halted SHALL be ignored.
REQ-034 Latency: word at car=A appears on control_signal exactly one cycle after car=A.
REQ-035 Control store writes SHALL be accepted in every state including reset and HALT.

Reset
REQ-036 rst=1 SHALL set car=0, control_signal=0, halted=0, illegal_op=0 at the next edge, overriding any sequencing or resume in that cycle.
REQ-037 Control store contents SHALL NOT be cleared by rst.
REQ-038 First cycle after rst deasserts SHALL execute store[0].

Verification
REQ-039 Under rst load store[0]={NEXT,ctrl=0x20}, store[1]={NEXT,0x10}, store[2]={MAP,0x2000}; release rst, opcode=0x02 -> control_signal 0x20,0x10,0x2000 on successive cycles, car then = 0x10.
REQ-040 store[0x28]={BRSET,csel=7,next=0x30,0x1}; flags=0x80 -> car=0x30; flags=0x00 -> car=0x29.
REQ-041 MAP with opcode=0x20 (CAR_WIDTH=8, MAP_SHIFT=3) -> illegal_op pulses once, car=0.
REQ-042 store[0x38]={HALT,0x8}; reach it -> control_signal=0x8 one cycle, then 0, halted=1 held 10 cycles; resume pulse -> halted=0, car=0, store[0] ctrl emitted one cycle later.
REQ-043 NEXT at car=0xFF -> car=0x00; rst asserted mid-branch -> car=0, control_signal=0 next edge, store contents intact.
REQ-044 Write store[car] during its execution -> old ctrl emitted; new ctrl emitted on next visit.
